// File: rtl/udp_rx_demux_if.sv
// Byte-stream bundle for udp_rx_demux: IPv4 input stream, demuxed payload stream and header info.
// The design consumes this through the slave modport; the upstream/downstream side uses master.
interface udp_rx_demux_if #(
    parameter int unsigned NUM_CH = 4
);
    logic [7:0]        udp_axis_tdata_in;
    logic              udp_axis_tvalid_in;
    logic              udp_axis_tlast_in;
    logic              udp_axis_tready_out;
    logic [7:0]        udpdata_tdata_out;
    logic [NUM_CH-1:0] udpdata_tvalid_out;
    logic              udpdata_tlast_out;
    logic [NUM_CH-1:0] udpdata_tready_in;
    logic [15:0]       udp_length_out;
    logic [31:0]       src_ip_out;
    logic [15:0]       src_port_out;
    logic [2:0]        ch_out;
    logic              hdr_valid_out;

    modport master (
        output udp_axis_tdata_in, udp_axis_tvalid_in, udp_axis_tlast_in, udpdata_tready_in,
        input  udp_axis_tready_out, udpdata_tdata_out, udpdata_tvalid_out, udpdata_tlast_out,
        input  udp_length_out, src_ip_out, src_port_out, ch_out, hdr_valid_out
    );

    modport slave (
        input  udp_axis_tdata_in, udp_axis_tvalid_in, udp_axis_tlast_in, udpdata_tready_in,
        output udp_axis_tready_out, udpdata_tdata_out, udpdata_tvalid_out, udpdata_tlast_out,
        output udp_length_out, src_ip_out, src_port_out, ch_out, hdr_valid_out
    );
endinterface

// File: rtl/udp_rx_demux.sv
// Parses IPv4/UDP headers from a byte stream and steers the payload to one of NUM_CH channels
// selected by destination port. Optional packet/drop counters are enabled by UDP_RX_STATS_EN.
module udp_rx_demux #(
    parameter int unsigned NUM_CH    = 4,
    parameter logic [15:0] PORT_BASE = 16'd8000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:0]  local_ip_addr,
    udp_rx_demux_if.slave bus
`ifdef UDP_RX_STATS_EN
    ,
    output logic [15:0]  pkt_cnt_out,
    output logic [15:0]  drop_cnt_out
`endif
);

    typedef enum logic [2:0] {StIdle, StIpHdr, StUdpHdr, StPayload, StDrop} state_e;

    state_e      state_q;
    logic [4:0]  cnt_q;
    logic [15:0] pay_cnt_q;
    logic [7:0]  ver_ihl_q;
    logic [7:0]  proto_q;
    logic [31:0] src_ip_q;
    logic [23:0] dst_ip_q;
    logic [15:0] sport_q;
    logic [15:0] dport_q;
    logic [15:0] len_q;

    logic        fire;
    logic [7:0]  din;
    logic        tlast;
    logic [31:0] dst_ip_full;
    logic        ip_ok;
    logic [15:0] ch_full;
    logic        port_bad;
    logic        len_short;
    logic        last_pay;

    assign din         = bus.udp_axis_tdata_in;
    assign tlast       = bus.udp_axis_tlast_in;
    assign fire        = bus.udp_axis_tvalid_in & bus.udp_axis_tready_out;
    // Destination IP is only complete with the byte currently on the bus.
    assign dst_ip_full = {dst_ip_q, din};
    assign ip_ok       = (ver_ihl_q == 8'h45) && (proto_q == 8'd17) &&
                         ((dst_ip_full == local_ip_addr) || (dst_ip_full == 32'hFFFF_FFFF));
    assign ch_full     = dport_q - PORT_BASE;
    assign port_bad    = (dport_q < PORT_BASE) || (ch_full >= 16'(NUM_CH));
    assign len_short   = len_q < 16'd8;
    assign last_pay    = pay_cnt_q == (bus.udp_length_out - 16'd1);

    assign bus.udpdata_tdata_out = din;

    always_comb begin
        bus.udp_axis_tready_out = 1'b1;
        bus.udpdata_tvalid_out  = '0;
        bus.udpdata_tlast_out   = 1'b0;
        if (state_q == StPayload) begin
            bus.udp_axis_tready_out = 1'b0;
            for (int i = 0; i < int'(NUM_CH); i++) begin
                if (bus.ch_out == 3'(i)) begin
                    bus.udp_axis_tready_out   = bus.udpdata_tready_in[i];
                    bus.udpdata_tvalid_out[i] = bus.udp_axis_tvalid_in;
                end
            end
            bus.udpdata_tlast_out = last_pay | tlast;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= StIdle;
            cnt_q              <= '0;
            pay_cnt_q          <= '0;
            ver_ihl_q          <= '0;
            proto_q            <= '0;
            src_ip_q           <= '0;
            dst_ip_q           <= '0;
            sport_q            <= '0;
            dport_q            <= '0;
            len_q              <= '0;
            bus.hdr_valid_out  <= 1'b0;
            bus.udp_length_out <= '0;
            bus.src_ip_out     <= '0;
            bus.src_port_out   <= '0;
            bus.ch_out         <= '0;
        end else begin
            bus.hdr_valid_out <= 1'b0;
            if (fire) begin
                unique case (state_q)
                    StIdle: begin
                        ver_ihl_q <= din;
                        cnt_q     <= 5'd1;
                        state_q   <= tlast ? StIdle : StIpHdr;
                    end
                    StIpHdr: begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q == 5'd9) proto_q <= din;
                        if (cnt_q >= 5'd12 && cnt_q <= 5'd15) src_ip_q <= {src_ip_q[23:0], din};
                        if (cnt_q >= 5'd16) dst_ip_q <= {dst_ip_q[15:0], din};
                        if (tlast) begin
                            state_q <= StIdle;
                        end else if (cnt_q == 5'd19) begin
                            cnt_q   <= '0;
                            state_q <= ip_ok ? StUdpHdr : StDrop;
                        end
                    end
                    StUdpHdr: begin
                        cnt_q <= cnt_q + 5'd1;
                        if (cnt_q <= 5'd1) sport_q <= {sport_q[7:0], din};
                        if (cnt_q == 5'd2 || cnt_q == 5'd3) dport_q <= {dport_q[7:0], din};
                        if (cnt_q == 5'd4 || cnt_q == 5'd5) len_q <= {len_q[7:0], din};
                        if (tlast) begin
                            state_q <= StIdle;
                        end else if (cnt_q == 5'd7) begin
                            cnt_q <= '0;
                            if (port_bad || len_short || len_q == 16'd8) begin
                                state_q <= StDrop;
                            end else begin
                                state_q            <= StPayload;
                                pay_cnt_q          <= '0;
                                bus.hdr_valid_out  <= 1'b1;
                                bus.udp_length_out <= len_q - 16'd8;
                                bus.src_ip_out     <= src_ip_q;
                                bus.src_port_out   <= sport_q;
                                bus.ch_out         <= ch_full[2:0];
                            end
                        end
                    end
                    StPayload: begin
                        pay_cnt_q <= pay_cnt_q + 16'd1;
                        // Payload complete but input continues: the rest is link padding.
                        if (last_pay) state_q <= tlast ? StIdle : StDrop;
                        else if (tlast) state_q <= StIdle;
                    end
                    StDrop: begin
                        if (tlast) state_q <= StIdle;
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

`ifdef UDP_RX_STATS_EN
    logic pkt_evt;
    logic drop_evt;

    assign pkt_evt  = fire && (state_q == StPayload) && last_pay;
    assign drop_evt = fire && (((state_q == StIdle) && tlast) ||
                               ((state_q == StIpHdr) && (tlast || (cnt_q == 5'd19 && !ip_ok))) ||
                               ((state_q == StUdpHdr) &&
                                (tlast || (cnt_q == 5'd7 && (port_bad || len_short)))) ||
                               ((state_q == StPayload) && tlast && !last_pay));

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_out  <= '0;
            drop_cnt_out <= '0;
        end else begin
            if (pkt_evt) pkt_cnt_out <= pkt_cnt_out + 16'd1;
            if (drop_evt) drop_cnt_out <= drop_cnt_out + 16'd1;
        end
    end
`endif

endmodule

// File: doc/udp_rx_demux.md
UDP_RX_DEMUX -- requirements
Module: udp_rx_demux

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of payload output channels, legal range 1..8.
REQ-002 SHALL have parameter PORT_BASE, default 16'd8000, UDP destination port mapped to channel 0.
REQ-003 SHALL have ports in this order:
- clk  in  1  single clock for all logic.
- reset  in  1  reset; synchronous, active-high.
- local_ip_addr  in  32  IPv4 address accepted as destination.
- udp_axis_tdata_in  in  8  IPv4 packet byte stream, Ethernet header already stripped.
- udp_axis_tvalid_in  in  1  input byte valid.
- udp_axis_tlast_in  in  1  last byte of the IP packet.
- udp_axis_tready_out  out  1  input ready.
- udpdata_tdata_out  out  8  payload byte, shared by all channels.
- udpdata_tvalid_out  out  NUM_CH  per-channel payload valid, one-hot or zero.
- udpdata_tlast_out  out  1  last payload byte.
- udpdata_tready_in  in  NUM_CH  per-channel ready.
- udp_length_out  out  16  payload length in bytes (UDP length - 8).
- src_ip_out  out  32  source IP of the current packet.
- src_port_out  out  16  UDP source port of the current packet.
- ch_out  out  3  selected channel index.
- hdr_valid_out  out  1  one-cycle pulse when the header is accepted.

Function
REQ-004 SHALL implement the states IDLE, IP_HDR, UDP_HDR, PAYLOAD and DROP.
REQ-005 udp_axis_tready_out SHALL be 1 in IDLE, IP_HDR, UDP_HDR and DROP; in PAYLOAD it SHALL equal udpdata_tready_in[ch].
REQ-006 A byte SHALL transfer only when valid and ready are both high; the byte counter SHALL advance only on a transfer.
REQ-007 IDLE SHALL move to IP_HDR on the first transfer, counting it as IP byte 0.
REQ-008 IP_HDR SHALL capture IP bytes 0..19: version/IHL at byte 0, protocol at 9, source IP at 12-15, destination IP at 16-19.
REQ-009 At the end of byte 19, the packet SHALL go to DROP unless all hold:
- byte 0 == 8'h45;
- protocol == 8'd17;
- destination IP == local_ip_addr or 32'hFFFFFFFF.
Otherwise it SHALL go to UDP_HDR.
REQ-010 UDP_HDR SHALL capture UDP bytes 0..7: source port, destination port, length; all big-endian.
REQ-011 At the end of UDP byte 7, ch = dest_port - PORT_BASE; the packet SHALL go to DROP when:
- dest_port < PORT_BASE, or ch >= NUM_CH;
- UDP length < 8.
REQ-012 When UDP length == 8, the packet SHALL go to DROP without pulsing hdr_valid_out; this is not counted as a drop.
REQ-013 Otherwise the packet SHALL go to PAYLOAD, with these outputs registered at entry and held until the next header: hdr_valid_out pulsed for one cycle, udp_length_out, src_ip_out, src_port_out, ch_out.
REQ-014 PAYLOAD SHALL pass data through combinationally with zero latency:
- udpdata_tdata_out = udp_axis_tdata_in;
- udpdata_tvalid_out[ch] = udp_axis_tvalid_in;
- all other tvalid bits 0.
REQ-015 udpdata_tlast_out SHALL assert on payload byte udp_length_out-1 or on input tlast, whichever comes first.
REQ-016 If input tlast arrives before the payload count is reached (truncation), the packet SHALL end there, return to IDLE and count as a drop.
REQ-017 If payload ends before input tlast (Ethernet padding), the packet SHALL go to DROP and discard bytes through input tlast.
REQ-018 Input tlast during IP_HDR or UDP_HDR SHALL return to IDLE and count as a drop.
REQ-019 DROP SHALL return to IDLE on the transfer that carries tlast.
REQ-020 Outside PAYLOAD, all udpdata_tvalid_out bits and udpdata_tlast_out SHALL be 0.

Reset
REQ-021 A reset cycle SHALL force the following, including mid-packet; the remaining bytes of that packet are then parsed as a new header:
- state = IDLE;
- counters = 0;
- udp_axis_tready_out = 1 (IDLE rule);
- udpdata_tvalid_out = 0, udpdata_tlast_out = 0, hdr_valid_out = 0;
- udp_length_out, src_ip_out, src_port_out, ch_out = 0.

Configuration
REQ-022 Macro UDP_RX_STATS_EN SHALL be the only compile option.
REQ-023 With UDP_RX_STATS_EN defined, the module SHALL add output ports pkt_cnt_out (16) and drop_cnt_out (16):
- pkt_cnt_out increments per completed payload;
- drop_cnt_out increments per dropped or truncated packet;
- both wrap at 16'hFFFF -> 0, and both are 0 after reset.
REQ-024 Without UDP_RX_STATS_EN, these ports and counters SHALL not exist, and all other behaviour SHALL be identical.

Verification
REQ-025 NUM_CH=4, PORT_BASE=8000; dest port 8002, UDP length 12, bytes 11 22 33 44, tready all 1 -> udpdata_tvalid_out=4'b0100 on 4 cycles, tlast on 8'h44, ch_out=2, udp_length_out=4, hdr_valid_out pulses once.
REQ-026 Dest port 8004 -> ch_out unchanged, no tvalid bits set, drop_cnt_out +1.
REQ-027 Protocol 6, then wrong destination IP 10.0.0.9 -> both dropped, tready stays 1 throughout, drop_cnt_out +2.
REQ-028 UDP length 12 with 6 padding bytes -> exactly 4 output bytes, tlast on the 4th, padding discarded, pkt_cnt_out +1.
REQ-029 Channel 1 with tready_in[1] toggling 1,0,1,0 -> udp_axis_tready_out follows it and no payload byte is lost or duplicated.
REQ-030 Reset asserted on payload byte 2 of 10 -> next cycle state IDLE, all tvalid bits 0, and the following packet is received correctly.
